// File: rtl/biriscv_csr_exec_mp_pkg.sv
// Shared decode constants, exception codes and result record for the CSR
// execute unit.
//   INST_* / *_MASK : instruction match value and mask pairs
//   EXC_*           : 6-bit exception codes carried on the result pipe
//   csr_result_t    : one result-pipe entry (all-zero means empty)
package biriscv_csr_exec_mp_pkg;

  localparam logic [31:0] INST_CSRRW    = 32'h0000_1073;
  localparam logic [31:0] INST_CSRRS    = 32'h0000_2073;
  localparam logic [31:0] INST_CSRRC    = 32'h0000_3073;
  localparam logic [31:0] INST_CSRRWI   = 32'h0000_5073;
  localparam logic [31:0] INST_CSRRSI   = 32'h0000_6073;
  localparam logic [31:0] INST_CSRRCI   = 32'h0000_7073;
  localparam logic [31:0] INST_CSR_MASK = 32'h0000_707f;
  localparam logic [31:0] INST_ECALL    = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK   = 32'h0010_0073;
  localparam logic [31:0] INST_MRET     = 32'h3020_0073;
  localparam logic [31:0] INST_WFI      = 32'h1050_0073;
  localparam logic [31:0] INST_FULL_MASK = 32'hffff_ffff;
  localparam logic [31:0] INST_IFENCE   = 32'h0000_100f;
  localparam logic [31:0] INST_IFENCE_MASK = 32'h0000_707f;
  localparam logic [31:0] INST_SFENCE   = 32'h1200_0073;
  localparam logic [31:0] INST_SFENCE_MASK = 32'hfe00_7fff;

  localparam logic [11:0] CSR_SATP = 12'h180;

  localparam logic [5:0] EXC_ILLEGAL_INSTRUCTION = 6'h12;
  localparam logic [5:0] EXC_BREAKPOINT          = 6'h13;
  localparam logic [5:0] EXC_ECALL               = 6'h18;
  localparam logic [5:0] EXC_ERET_M              = 6'h33;
  localparam logic [5:0] EXC_FENCE               = 6'h21;

  localparam logic [1:0] PRIV_USER    = 2'd0;
  localparam logic [1:0] PRIV_SUPER   = 2'd1;
  localparam logic [1:0] PRIV_MACHINE = 2'd3;

  typedef enum logic {WFI_IDLE = 1'b0, WFI_SLEEP = 1'b1} wfi_state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] value;
    logic [31:0] wdata;
    logic [5:0]  exception;
    logic [1:0]  lane;
  } csr_result_t;

  function automatic logic op_match(input logic [31:0] op, input logic [31:0] val,
                                    input logic [31:0] mask);
    return (op & mask) == val;
  endfunction

endpackage

// File: rtl/biriscv_csr_exec_mp_result.sv
// biriscv_csr_result_pipe: STAGES-deep register chain for CSR results.
//   clk_i/rst_i : clock, async active-high reset
//   flush_i     : zero every stage (including the entry being written)
//   res_i       : new entry (zero when nothing issued)
//   res_o       : tail entry
module biriscv_csr_result_pipe
  import biriscv_csr_exec_mp_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  csr_result_t res_i,
  output csr_result_t res_o
);

  csr_result_t stage_q [STAGES];
  csr_result_t stage_d [STAGES];

  always_comb begin
    stage_d[0] = flush_i ? '0 : res_i;
    for (int i = 1; i < STAGES; i++)
      stage_d[i] = flush_i ? '0 : stage_q[i-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign res_o = stage_q[STAGES-1];

endmodule

// File: rtl/biriscv_csr_exec_mp.sv
// biriscv_csr_exec_mp: CSR / system-op execute unit for up to LANES issue
// slots. The oldest valid lane is accepted (unless sleeping in WFI), its CSR
// is read combinationally, and the decoded result travels down a
// RESULT_STAGES-deep pipe. Redirect, interrupt and fence side-effects are
// registered single-cycle outputs.
//   opcode_*_i  : per-lane op, packed lane n at [W*n +: W]
//   csr_*       : regfile read port and trap/return redirect
//   accept_o    : one-hot lane consumed this cycle
//   result_*_o  : result-pipe tail
module biriscv_csr_exec_mp
  import biriscv_csr_exec_mp_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int LANES         = 2,
  parameter int RESULT_STAGES = 1,
  parameter int SUPPORT_SUPER = 1,
  parameter int SUPPORT_WFI   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [LANES-1:0]      opcode_valid_i,
  input  logic [32*LANES-1:0]   opcode_opcode_i,
  input  logic [LANES-1:0]      opcode_invalid_i,
  input  logic [5*LANES-1:0]    opcode_ra_idx_i,
  input  logic [XLEN*LANES-1:0] opcode_ra_operand_i,
  output logic [11:0]           csr_raddr_o,
  input  logic [XLEN-1:0]       csr_rdata_i,
  input  logic [1:0]            priv_i,
  input  logic                  irq_pending_i,
  input  logic                  interrupt_inhibit_i,
  input  logic                  flush_i,
  input  logic [31:0]           reset_vector_i,
  input  logic                  csr_branch_i,
  input  logic [31:0]           csr_target_i,
  output logic [LANES-1:0]      accept_o,
  output logic                  stall_o,
  output logic                  result_write_o,
  output logic [XLEN-1:0]       result_value_o,
  output logic [XLEN-1:0]       result_wdata_o,
  output logic [5:0]            result_exception_o,
  output logic [1:0]            result_lane_o,
  output logic                  branch_request_o,
  output logic [31:0]           branch_pc_o,
  output logic                  take_interrupt_o,
  output logic                  ifence_o,
  output logic                  tlb_flush_o
);

  wfi_state_e state_q;
  logic       stall_q;

  // Oldest (lowest-index) valid lane wins.
  int   sel_idx;
  logic sel_valid;
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = 0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (opcode_valid_i[i]) begin
        sel_valid = 1'b1;
        sel_idx   = i;
      end
    end
  end

  logic [31:0]      op;
  logic [4:0]       ra_idx;
  logic [XLEN-1:0]  data, wdata;
  logic             take, set_w, clr_w, csr_wr, fault, satp_wr;
  logic             is_ecall, is_ebreak, is_mret, is_wfi, is_fencei, is_sfence, illegal;
  logic [5:0]       exc;
  logic [LANES-1:0] accept;
  csr_result_t      res_in;

  always_comb begin
    op        = opcode_opcode_i[32*sel_idx +: 32];
    ra_idx    = opcode_ra_idx_i[5*sel_idx +: 5];
    take      = sel_valid & ~stall_q;
    accept    = '0;
    if (take) accept[sel_idx] = 1'b1;

    set_w  = op_match(op, INST_CSRRW, INST_CSR_MASK) | op_match(op, INST_CSRRS, INST_CSR_MASK) |
             op_match(op, INST_CSRRWI, INST_CSR_MASK) | op_match(op, INST_CSRRSI, INST_CSR_MASK);
    clr_w  = op_match(op, INST_CSRRW, INST_CSR_MASK) | op_match(op, INST_CSRRC, INST_CSR_MASK) |
             op_match(op, INST_CSRRWI, INST_CSR_MASK) | op_match(op, INST_CSRRCI, INST_CSR_MASK);
    csr_wr = (ra_idx != 5'd0) | op_match(op, INST_CSRRW, INST_CSR_MASK) |
             op_match(op, INST_CSRRWI, INST_CSR_MASK);
    // funct3[2] marks the zimm forms
    data   = op[14] ? {{(XLEN-5){1'b0}}, ra_idx} : opcode_ra_operand_i[XLEN*sel_idx +: XLEN];

    // Writes to CSR[31:30]==3 are read-only; CSR[29:28] is the minimum privilege.
    fault  = (SUPPORT_SUPER != 0) & (set_w | clr_w) &
             ((csr_wr & (op[31:30] == 2'b11)) | (priv_i < op[29:28]));
    illegal = opcode_invalid_i[sel_idx] | fault;

    wdata = '0;
    if (set_w & clr_w)  wdata = data;
    else if (set_w)     wdata = csr_rdata_i | data;
    else if (clr_w)     wdata = csr_rdata_i & ~data;

    is_ecall  = op_match(op, INST_ECALL,  INST_FULL_MASK);
    is_ebreak = op_match(op, INST_EBREAK, INST_FULL_MASK);
    is_mret   = op_match(op, INST_MRET,   INST_FULL_MASK);
    is_wfi    = op_match(op, INST_WFI,    INST_FULL_MASK);
    is_fencei = op_match(op, INST_IFENCE, INST_IFENCE_MASK);
    is_sfence = op_match(op, INST_SFENCE, INST_SFENCE_MASK);
    satp_wr   = (set_w | clr_w) & csr_wr & ~fault & (op[31:20] == CSR_SATP);

    exc = 6'h0;
    if (is_ecall)                            exc = EXC_ECALL + {4'b0, priv_i};
    else if (is_mret)                        exc = EXC_ERET_M;
    else if (is_ebreak)                      exc = EXC_BREAKPOINT;
    else if (illegal)                        exc = EXC_ILLEGAL_INSTRUCTION;
    else if (satp_wr | is_fencei | is_sfence) exc = EXC_FENCE;

    res_in = '0;
    if (take) begin
      res_in.write     = (set_w | clr_w) & ~fault;
      res_in.value     = illegal ? op : csr_rdata_i;
      res_in.wdata     = wdata;
      res_in.exception = exc;
      res_in.lane      = 2'(sel_idx);
    end
  end

  assign accept_o    = accept;
  assign csr_raddr_o = sel_valid ? op[31:20] : 12'h0;

  csr_result_t res_tail;
  biriscv_csr_result_pipe #(.STAGES(RESULT_STAGES)) u_pipe (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .res_i(res_in), .res_o(res_tail)
  );

  assign result_write_o     = res_tail.write;
  assign result_value_o     = res_tail.value;
  assign result_wdata_o     = res_tail.wdata;
  assign result_exception_o = res_tail.exception;
  assign result_lane_o      = res_tail.lane;

  // WFI sleep: flush wins over entry; a pending irq only wakes from SLEEP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= WFI_IDLE;
      stall_q <= 1'b0;
    end else begin
      case (state_q)
        WFI_IDLE: if (take & is_wfi & (SUPPORT_WFI != 0) & ~flush_i) begin
          state_q <= WFI_SLEEP;
          stall_q <= 1'b1;
        end
        WFI_SLEEP: if (irq_pending_i | flush_i) begin
          state_q <= WFI_IDLE;
          stall_q <= 1'b0;
        end
        default: begin
          state_q <= WFI_IDLE;
          stall_q <= 1'b0;
        end
      endcase
    end
  end

  // boot_q is set through reset so the first clock afterwards redirects to
  // the reset vector.
  logic        boot_q, boot_d, branch_q, branch_d, take_int_q, take_int_d;
  logic        ifence_q, ifence_d, tlb_flush_q, tlb_flush_d;
  logic [31:0] branch_pc_q, branch_pc_d;

  always_comb begin
    boot_d      = 1'b0;
    branch_d    = boot_q | csr_branch_i;
    branch_pc_d = boot_q ? reset_vector_i : csr_target_i;
    take_int_d  = irq_pending_i & ~interrupt_inhibit_i;
    ifence_d    = take & is_fencei & ~flush_i;
    tlb_flush_d = take & (is_sfence | satp_wr) & ~flush_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      boot_q      <= 1'b1;
      branch_q    <= 1'b0;
      branch_pc_q <= 32'h0;
      take_int_q  <= 1'b0;
      ifence_q    <= 1'b0;
      tlb_flush_q <= 1'b0;
    end else begin
      boot_q      <= boot_d;
      branch_q    <= branch_d;
      branch_pc_q <= branch_pc_d;
      take_int_q  <= take_int_d;
      ifence_q    <= ifence_d;
      tlb_flush_q <= tlb_flush_d;
    end
  end

  assign stall_o          = stall_q;
  assign branch_request_o = branch_q;
  assign branch_pc_o      = branch_pc_q;
  assign take_interrupt_o = take_int_q;
  assign ifence_o         = ifence_q;
  assign tlb_flush_o      = tlb_flush_q;

endmodule

// File: tb/tb_biriscv_csr_exec_mp.sv
module tb_biriscv_csr_exec_mp;
  localparam int LANES = 2;

  typedef struct packed {
    logic        w;
    logic [31:0] v;
    logic [31:0] d;
    logic [5:0]  e;
    logic [1:0]  l;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [LANES-1:0]    valid, inv;
  logic [32*LANES-1:0] opc, ra_op;
  logic [5*LANES-1:0]  ra_idx;
  logic [31:0]         rdata, rv, tgt;
  logic [1:0]          priv;
  logic                irq, inh, flush, cbr;

  logic [11:0] raddr_a, raddr_b;
  logic [LANES-1:0] acc_a, acc_b;
  logic stall_a, stall_b, rw_a, rw_b, br_a, br_b, ti_a, ti_b, if_a, if_b, tlb_a, tlb_b;
  logic [31:0] rval_a, rval_b, rwd_a, rwd_b, bpc_a, bpc_b;
  logic [5:0] rex_a, rex_b;
  logic [1:0] rl_a, rl_b;

  biriscv_csr_exec_mp #(.XLEN(32), .LANES(LANES), .RESULT_STAGES(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .opcode_valid_i(valid), .opcode_opcode_i(opc),
    .opcode_invalid_i(inv), .opcode_ra_idx_i(ra_idx), .opcode_ra_operand_i(ra_op),
    .csr_raddr_o(raddr_a), .csr_rdata_i(rdata), .priv_i(priv), .irq_pending_i(irq),
    .interrupt_inhibit_i(inh), .flush_i(flush), .reset_vector_i(rv),
    .csr_branch_i(cbr), .csr_target_i(tgt), .accept_o(acc_a), .stall_o(stall_a),
    .result_write_o(rw_a), .result_value_o(rval_a), .result_wdata_o(rwd_a),
    .result_exception_o(rex_a), .result_lane_o(rl_a), .branch_request_o(br_a),
    .branch_pc_o(bpc_a), .take_interrupt_o(ti_a), .ifence_o(if_a), .tlb_flush_o(tlb_a));

  biriscv_csr_exec_mp #(.XLEN(32), .LANES(LANES), .RESULT_STAGES(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .opcode_valid_i(valid), .opcode_opcode_i(opc),
    .opcode_invalid_i(inv), .opcode_ra_idx_i(ra_idx), .opcode_ra_operand_i(ra_op),
    .csr_raddr_o(raddr_b), .csr_rdata_i(rdata), .priv_i(priv), .irq_pending_i(irq),
    .interrupt_inhibit_i(inh), .flush_i(flush), .reset_vector_i(rv),
    .csr_branch_i(cbr), .csr_target_i(tgt), .accept_o(acc_b), .stall_o(stall_b),
    .result_write_o(rw_b), .result_value_o(rval_b), .result_wdata_o(rwd_b),
    .result_exception_o(rex_b), .result_lane_o(rl_b), .branch_request_o(br_b),
    .branch_pc_o(bpc_b), .take_interrupt_o(ti_b), .ifence_o(if_b), .tlb_flush_o(tlb_b));

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  res_t ent [0:4095];
  bit   fl  [0:4095];
  int   cyc;
  bit   sleep, boot, e_br, e_ti, e_if, e_tlb;
  logic [31:0] e_pc;

  logic [11:0] csr_tbl [8] = '{12'h340, 12'hC00, 12'h180, 12'h300, 12'h100, 12'h7C0, 12'hF11, 12'h141};
  logic [2:0]  f3_tbl  [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // What this cycle's inputs mean, from the ISA field definitions.
  function automatic void model_now(output int sel, output bit take, output res_t r,
                                    output bit wfi, output bit fi, output bit tlb,
                                    output logic [11:0] ra);
    logic [31:0] op, opnd, data;
    logic [4:0]  idx;
    logic [2:0]  f3;
    bit csr, iv, fault, wr, satp, sf;
    sel = -1;
    for (int i = 0; i < LANES; i++) if (valid[i] && sel < 0) sel = i;
    take = 0; r = '0; wfi = 0; fi = 0; tlb = 0; ra = '0;
    if (sel < 0) return;
    op = opc[32*sel +: 32]; idx = ra_idx[5*sel +: 5]; opnd = ra_op[32*sel +: 32]; iv = inv[sel];
    ra = op[31:20];
    take = !sleep;
    f3 = op[14:12];
    csr = (op[6:0] == 7'h73) && (f3 != 3'd0) && (f3 != 3'd4);
    wr = (idx != 0) || (f3[1:0] == 2'b01);
    data = f3[2] ? {27'd0, idx} : opnd;
    fault = csr && ((wr && op[31:30] == 2'b11) || (priv < op[29:28]));
    if (csr) begin
      case (f3[1:0])
        2'b01:   r.d = data;
        2'b10:   r.d = rdata | data;
        default: r.d = rdata & ~data;
      endcase
    end
    r.v = (iv || fault) ? op : rdata;
    r.w = csr && !fault;
    r.l = 2'(sel);
    satp = csr && wr && !fault && (op[31:20] == 12'h180);
    fi   = (op[6:0] == 7'h0f) && (f3 == 3'd1);
    sf   = (op[31:25] == 7'h09) && (op[14:0] == 15'h0073);
    wfi  = (op == 32'h10500073);
    tlb  = sf || satp;
    if (op == 32'h00000073)      r.e = 6'h18 + {4'd0, priv};
    else if (op == 32'h30200073) r.e = 6'h33;
    else if (op == 32'h00100073) r.e = 6'h13;
    else if (iv || fault)        r.e = 6'h12;
    else if (satp || fi || sf)   r.e = 6'h21;
  endfunction

  // Tail of a depth-d pipe: the op issued d cycles ago, unless a flush happened since.
  function automatic res_t exp_tail(input int d);
    int idx;
    idx = cyc - d;
    if (idx < 0) return '0;
    for (int k = idx; k < cyc; k++) if (fl[k]) return '0;
    return ent[idx];
  endfunction

  task automatic check_all();
    int sel; bit take, w, f, t; res_t r; logic [11:0] ra; logic [LANES-1:0] ea;
    model_now(sel, take, r, w, f, t, ra);
    ea = '0;
    if (take) ea[sel] = 1'b1;
    chk("accept", {acc_a, acc_b}, {ea, ea});
    chk("csr_raddr", {raddr_a, raddr_b}, {ra, ra});
    chk("stall", {stall_a, stall_b}, {sleep, sleep});
    chk("tail_rs1", {rw_a, rval_a, rwd_a, rex_a, rl_a}, exp_tail(1));
    chk("tail_rs3", {rw_b, rval_b, rwd_b, rex_b, rl_b}, exp_tail(3));
    chk("branch_req", {br_a, br_b}, {e_br, e_br});
    if (e_br) chk("branch_pc", {bpc_a, bpc_b}, {e_pc, e_pc});
    chk("take_int", {ti_a, ti_b}, {e_ti, e_ti});
    chk("ifence", {if_a, if_b}, {e_if, e_if});
    chk("tlb_flush", {tlb_a, tlb_b}, {e_tlb, e_tlb});
  endtask

  task automatic update_model();
    int sel; bit take, w, f, t; res_t r; logic [11:0] ra;
    model_now(sel, take, r, w, f, t, ra);
    ent[cyc] = (take && !flush) ? r : '0;
    fl[cyc]  = flush;
    e_br  = boot || cbr;
    e_pc  = boot ? rv : tgt;
    boot  = 0;
    e_ti  = irq && !inh;
    e_if  = take && f && !flush;
    e_tlb = take && t && !flush;
    if (sleep) begin
      if (irq || flush) sleep = 0;
    end else if (take && w && !flush) sleep = 1;
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk); check_all();
    @(posedge clk); update_model(); #1;
  endtask

  task automatic idle();
    valid = '0; inv = '0; opc = '0; ra_idx = '0; ra_op = '0; rdata = '0;
    irq = 0; inh = 0; flush = 0; cbr = 0; tgt = '0;
  endtask

  function automatic logic [31:0] rand_op(input logic [4:0] rs1);
    int k;
    k = $urandom_range(0, 15);
    case (k)
      8:  return 32'h00000073;
      9:  return 32'h00100073;
      10: return 32'h30200073;
      11: return 32'h10500073;
      12: return 32'h0000100f;
      13: return {7'h09, 5'($urandom), rs1, 3'b000, 5'b0, 7'h73};
      14: return $urandom;
      default: return {csr_tbl[$urandom_range(0, 7)], rs1, f3_tbl[$urandom_range(0, 5)],
                       5'($urandom), 7'h73};
    endcase
  endfunction

  initial begin
    idle(); priv = 2'd3; rv = 32'h8000_0000;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tail", {rw_a, rval_a, rwd_a, rex_a, rl_a, rw_b, rval_b, rwd_b, rex_b, rl_b}, '0);
    chk("rst_flags", {stall_a, br_a, bpc_a, ti_a, if_a, tlb_a}, '0);
    rst = 0;
    cyc = 0; sleep = 0; boot = 1; e_br = 0; e_ti = 0; e_if = 0; e_tlb = 0; e_pc = '0;

    // Boot redirect pulse
    cycle();
    chk("boot_branch", {br_a, bpc_a}, {1'b1, 32'h8000_0000});
    cycle();
    chk("boot_pulse_end", br_a, 1'b0);

    // CSRRS mscratch, rs1=x5=0xF0, rdata=0xF
    valid = 2'b01; opc[31:0] = 32'h3402A0F3; ra_idx[4:0] = 5'd5; ra_op[31:0] = 32'hF0;
    rdata = 32'h00F; #1;
    chk("d_accept_csrrs", acc_a, 2'b01);
    cycle();
    idle();
    chk("d_csrrs_rs1", {rw_a, rval_a, rwd_a, rex_a, rl_a}, {1'b1, 32'h00F, 32'h0FF, 6'h0, 2'd0});
    cycle(); cycle();
    chk("d_csrrs_rs3", {rw_b, rval_b, rwd_b, rex_b, rl_b}, {1'b1, 32'h00F, 32'h0FF, 6'h0, 2'd0});

    // ECALL on lane 0 and CSRRW on lane 1: lane 0 first, lane 1 replayed
    valid = 2'b11; opc = {32'h34029073, 32'h00000073}; ra_idx = {5'd5, 5'd0};
    ra_op = {32'h1234_5678, 32'h0}; #1;
    chk("d_accept_both", acc_a, 2'b01);
    cycle();
    chk("d_ecall_m", {rex_a, rl_a}, {6'h1B, 2'd0});
    valid = 2'b10; #1;
    chk("d_accept_replay", acc_a, 2'b10);
    cycle();
    chk("d_csrrw_lane1", {rw_a, rwd_a, rl_a}, {1'b1, 32'h1234_5678, 2'd1});
    idle();

    // CSRRW to read-only cycle CSR
    valid = 2'b01; opc[31:0] = 32'hC0029073; ra_idx[4:0] = 5'd5; ra_op[31:0] = 32'h55;
    cycle();
    chk("d_ro_fault", {rw_a, rval_a, rex_a}, {1'b0, 32'hC0029073, 6'h12});
    idle();

    // WFI sleep and wake by irq
    valid = 2'b01; opc[31:0] = 32'h10500073;
    cycle();
    chk("d_wfi_stall", stall_a, 1'b1);
    opc[31:0] = 32'h3402A0F3; #1;
    chk("d_sleep_accept", acc_a, 2'b00);
    cycle(); cycle();
    chk("d_still_sleep", stall_a, 1'b1);
    irq = 1;
    cycle();
    irq = 0;
    chk("d_wake", stall_a, 1'b0);
    #1;
    chk("d_accept_after_wake", acc_a, 2'b01);
    idle();
    cycle(); cycle(); cycle();

    // Three ops back to back then flush: only the first reaches the depth-3 tail
    valid = 2'b01; opc[31:0] = 32'h3402A0F3; ra_idx[4:0] = 5'd5; ra_op[31:0] = 32'h0;
    rdata = 32'h111; cycle();
    rdata = 32'h222; cycle();
    rdata = 32'h333; cycle();
    chk("d_flush_first", {rw_b, rval_b}, {1'b1, 32'h111});
    idle(); flush = 1;
    cycle();
    flush = 0;
    chk("d_flush_zero", {rw_b, rval_b, rwd_b, rex_b, rl_b, rw_a, rval_a}, '0);
    cycle(); cycle();
    chk("d_flush_gone", {rw_b, rval_b, rwd_b, rex_b, rl_b}, '0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      for (int l = 0; l < LANES; l++) begin
        logic [4:0] rs;
        rs = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        valid[l] = ($urandom_range(0, 9) < 6);
        inv[l] = ($urandom_range(0, 15) == 0);
        ra_idx[5*l +: 5] = rs;
        opc[32*l +: 32] = rand_op(rs);
        ra_op[32*l +: 32] = $urandom;
      end
      rdata = $urandom;
      priv = 2'($urandom_range(0, 2));
      if (priv == 2'd2) priv = 2'd3;
      irq = ($urandom_range(0, 9) == 0);
      inh = $urandom_range(0, 1) == 1;
      flush = ($urandom_range(0, 19) == 0);
      cbr = ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      cycle();
    end
    idle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
